// File: rtl/branch_pc_unit_if.sv
// Fetch-address handshake between the PC unit (master) and instruction memory (slave).
// addr is held stable by the master while valid is high and ready is low.
interface branch_pc_unit_if #(
    parameter int DATA_SIZE = 32
);
    logic                 valid;
    logic                 ready;
    logic [DATA_SIZE-1:0] addr;

    modport master (
        output valid,
        output addr,
        input  ready
    );

    modport slave (
        input  valid,
        input  addr,
        output ready
    );
endinterface

// File: rtl/branch_pc_unit.sv
// Branch/jump resolution and program counter register for the single-cycle core.
// Redirects or steps the PC on each accepted fetch and counts the taken redirects.
module branch_pc_unit #(
    parameter int                   DATA_SIZE = 32,
    parameter logic [DATA_SIZE-1:0] RESET_PC  = '0,
    parameter int                   CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 stall_i,
    input  logic                 is_branch_i,
    input  logic                 is_jal_i,
    input  logic                 is_jalr_i,
    input  logic [2:0]           funct3_i,
    input  logic                 BrEq_i,
    input  logic                 BrLT_i,
    input  logic [DATA_SIZE-1:0] target_i,
    branch_pc_unit_if.master     imem_if,
    output logic                 BrUn_o,
    output logic [DATA_SIZE-1:0] pc_plus4_o,
    output logic                 taken_o,
    output logic                 illegal_br_o,
    output logic                 trap_o,
    output logic [CNT_W-1:0]     taken_cnt_o
);

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        HOLD,
        TRAP
    } state_e;

    state_e               state_q;
    logic [DATA_SIZE-1:0] pc_q;
    logic                 valid_q;
    logic                 trap_q;
    logic [CNT_W-1:0]     cnt_q;

    logic                 cond;
    logic [DATA_SIZE-1:0] redirect_pc;
    logic [DATA_SIZE-1:0] next_pc_d;
    logic                 misaligned;
    logic                 accept;

    // Branch condition, redirect target and fetch-accept decode.
    always_comb begin
        cond = 1'b0;
        unique case (funct3_i)
            3'b000:         cond = BrEq_i;
            3'b001:         cond = ~BrEq_i;
            3'b100, 3'b110: cond = BrLT_i;
            3'b101, 3'b111: cond = ~BrLT_i;
            default:        cond = 1'b0;
        endcase

        BrUn_o       = funct3_i[1];
        illegal_br_o = is_branch_i & (funct3_i[2:1] == 2'b01);
        taken_o      = is_jalr_i | is_jal_i | (is_branch_i & cond);
        pc_plus4_o   = pc_q + DATA_SIZE'(4);

        // JALR takes priority and always clears bit 0 of its target.
        redirect_pc = target_i;
        if (is_jalr_i) begin
            redirect_pc[0] = 1'b0;
        end

        next_pc_d  = taken_o ? redirect_pc : pc_plus4_o;
        misaligned = taken_o & (next_pc_d[1:0] != 2'b00);
        accept     = ((state_q == RUN) || (state_q == HOLD)) & imem_if.ready & ~stall_i;
    end

    // Fetch FSM; the PC only moves on an accepted handshake, and stall overrides ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
            valid_q <= 1'b0;
            trap_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            unique case (state_q)
                BOOT: begin
                    state_q <= RUN;
                    valid_q <= 1'b1;
                end
                RUN, HOLD: begin
                    if (accept) begin
                        if (misaligned) begin
                            state_q <= TRAP;
                            valid_q <= 1'b0;
                            trap_q  <= 1'b1;
                        end else begin
                            state_q <= RUN;
                            pc_q    <= next_pc_d;
                            if (taken_o && !(&cnt_q)) begin
                                cnt_q <= cnt_q + CNT_W'(1);
                            end
                        end
                    end else begin
                        state_q <= HOLD;
                    end
                end
                TRAP: begin
                    state_q <= TRAP;
                end
                default: begin
                    state_q <= BOOT;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign imem_if.valid = valid_q;
    assign imem_if.addr  = pc_q;
    assign trap_o        = trap_q;
    assign taken_cnt_o   = cnt_q;

endmodule

// File: tb/tb_branch_pc_unit.sv
// Scenario-driven bench for branch_pc_unit; expected fetch addresses are queued
// when stimulus is applied and popped when the PC register presents them.
module tb_branch_pc_unit;
    localparam int DW = 32;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          stall = 1'b0;
    logic          isBranch = 1'b0;
    logic          isJal = 1'b0;
    logic          isJalr = 1'b0;
    logic [2:0]    funct3 = 3'b000;
    logic          brEq = 1'b0;
    logic          brLt = 1'b0;
    logic [DW-1:0] target = '0;
    logic          brUn;
    logic          taken;
    logic          illegalBr;
    logic          trap;
    logic [DW-1:0] pcPlus4;
    logic [CW-1:0] takenCnt;
    logic [CW-1:0] expCnt = '0;
    logic [DW-1:0] expPcQ[$];
    logic [DW-1:0] expPc;
    int            checks = 0;
    int            failures = 0;

    branch_pc_unit_if #(.DATA_SIZE(DW)) imemIf();

    branch_pc_unit #(
        .DATA_SIZE(DW),
        .RESET_PC (32'h0000_0000),
        .CNT_W    (CW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall_i     (stall),
        .is_branch_i (isBranch),
        .is_jal_i    (isJal),
        .is_jalr_i   (isJalr),
        .funct3_i    (funct3),
        .BrEq_i      (brEq),
        .BrLT_i      (brLt),
        .target_i    (target),
        .imem_if     (imemIf),
        .BrUn_o      (brUn),
        .pc_plus4_o  (pcPlus4),
        .taken_o     (taken),
        .illegal_br_o(illegalBr),
        .trap_o      (trap),
        .taken_cnt_o (takenCnt)
    );

    always #5 clk = ~clk;

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clearInputs();
        isBranch = 1'b0; isJal = 1'b0; isJalr = 1'b0;
        funct3 = 3'b000; brEq = 1'b0; brLt = 1'b0; target = '0; stall = 1'b0;
    endtask

    task automatic test_reset();
        imemIf.ready = 1'b1;
        #2;
        checks++; if (imemIf.addr !== 32'h0) begin failures++; $display("[TB] FAIL reset_pc: got %h expected %h", imemIf.addr, 32'h0); end
        checks++; if (imemIf.valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid: got %b expected 0", imemIf.valid); end
        checks++; if (trap !== 1'b0) begin failures++; $display("[TB] FAIL reset_trap: got %b expected 0", trap); end
        checks++; if (takenCnt !== '0) begin failures++; $display("[TB] FAIL reset_cnt: got %0d expected 0", takenCnt); end
        rst_n = 1'b1;
        expPcQ.push_back(32'h0); expPcQ.push_back(32'h4); expPcQ.push_back(32'h8);
        for (int i = 0; i < 3; i++) begin
            stepCycle();
            expPc = expPcQ.pop_front();
            checks++; if (imemIf.addr !== expPc) begin failures++; $display("[TB] FAIL boot_pc[%0d]: got %h expected %h", i, imemIf.addr, expPc); end
            checks++; if (imemIf.valid !== 1'b1) begin failures++; $display("[TB] FAIL boot_valid[%0d]: got %b expected 1", i, imemIf.valid); end
        end
    endtask

    task automatic test_beq();
        isBranch = 1'b1; funct3 = 3'b000; brEq = 1'b1; target = 32'h100;
        #1;
        checks++; if (taken !== 1'b1) begin failures++; $display("[TB] FAIL beq_taken: got %b expected 1", taken); end
        checks++; if (brUn !== 1'b0) begin failures++; $display("[TB] FAIL beq_brun: got %b expected 0", brUn); end
        checks++; if (pcPlus4 !== 32'hC) begin failures++; $display("[TB] FAIL beq_pcplus4: got %h expected %h", pcPlus4, 32'hC); end
        expPcQ.push_back(32'h100); expCnt = 3'd1;
        stepCycle();
        clearInputs();
        expPc = expPcQ.pop_front();
        checks++; if (imemIf.addr !== expPc) begin failures++; $display("[TB] FAIL beq_pc: got %h expected %h", imemIf.addr, expPc); end
        checks++; if (takenCnt !== expCnt) begin failures++; $display("[TB] FAIL beq_cnt: got %0d expected %0d", takenCnt, expCnt); end
    endtask

    task automatic test_unsigned();
        isBranch = 1'b1; funct3 = 3'b111; brLt = 1'b1; target = 32'h300;
        #1;
        checks++; if (taken !== 1'b0) begin failures++; $display("[TB] FAIL bgeu_taken: got %b expected 0", taken); end
        checks++; if (brUn !== 1'b1) begin failures++; $display("[TB] FAIL bgeu_brun: got %b expected 1", brUn); end
        expPcQ.push_back(32'h104);
        stepCycle();
        expPc = expPcQ.pop_front();
        checks++; if (imemIf.addr !== expPc) begin failures++; $display("[TB] FAIL bgeu_pc: got %h expected %h", imemIf.addr, expPc); end
        funct3 = 3'b110; target = 32'h40;
        #1;
        checks++; if (brUn !== 1'b1) begin failures++; $display("[TB] FAIL bltu_brun: got %b expected 1", brUn); end
        expPcQ.push_back(32'h40); expCnt = 3'd2;
        stepCycle();
        clearInputs();
        expPc = expPcQ.pop_front();
        checks++; if (imemIf.addr !== expPc) begin failures++; $display("[TB] FAIL bltu_pc: got %h expected %h", imemIf.addr, expPc); end
        checks++; if (takenCnt !== expCnt) begin failures++; $display("[TB] FAIL bltu_cnt: got %0d expected %0d", takenCnt, expCnt); end
    endtask

    task automatic test_illegal();
        isBranch = 1'b1; funct3 = 3'b010; brEq = 1'b1; target = 32'h500;
        #1;
        checks++; if (illegalBr !== 1'b1) begin failures++; $display("[TB] FAIL illegal_flag: got %b expected 1", illegalBr); end
        checks++; if (taken !== 1'b0) begin failures++; $display("[TB] FAIL illegal_taken: got %b expected 0", taken); end
        expPcQ.push_back(32'h44);
        stepCycle();
        clearInputs();
        expPc = expPcQ.pop_front();
        checks++; if (imemIf.addr !== expPc) begin failures++; $display("[TB] FAIL illegal_pc: got %h expected %h", imemIf.addr, expPc); end
    endtask

    task automatic test_stall();
        isJal = 1'b1; target = 32'h80; imemIf.ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            stepCycle();
            checks++; if (imemIf.addr !== 32'h44) begin failures++; $display("[TB] FAIL notready_pc[%0d]: got %h expected %h", i, imemIf.addr, 32'h44); end
            checks++; if (imemIf.valid !== 1'b1) begin failures++; $display("[TB] FAIL notready_valid[%0d]: got %b expected 1", i, imemIf.valid); end
        end
        imemIf.ready = 1'b1; stall = 1'b1;
        stepCycle();
        checks++; if (imemIf.addr !== 32'h44) begin failures++; $display("[TB] FAIL stall_pc: got %h expected %h", imemIf.addr, 32'h44); end
        checks++; if (takenCnt !== expCnt) begin failures++; $display("[TB] FAIL stall_cnt: got %0d expected %0d", takenCnt, expCnt); end
        stall = 1'b0;
        expPcQ.push_back(32'h80); expCnt = expCnt + 3'd1;
        stepCycle();
        clearInputs();
        expPc = expPcQ.pop_front();
        checks++; if (imemIf.addr !== expPc) begin failures++; $display("[TB] FAIL jal_pc: got %h expected %h", imemIf.addr, expPc); end
        checks++; if (takenCnt !== expCnt) begin failures++; $display("[TB] FAIL jal_cnt: got %0d expected %0d", takenCnt, expCnt); end
    endtask

    // Consecutive redirects: JAL, JALR (bit 0 cleared), then JAL+JALR where JALR wins;
    // the last two entries push the counter into saturation.
    task automatic test_back_to_back();
        logic          jalTab [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        logic          jalrTab[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [DW-1:0] tgtTab [5] = '{32'h10, 32'h21, 32'h31, 32'h50, 32'h60};
        logic [DW-1:0] expTab [5] = '{32'h10, 32'h20, 32'h30, 32'h50, 32'h60};
        for (int i = 0; i < 5; i++) begin
            isJal = jalTab[i]; isJalr = jalrTab[i]; target = tgtTab[i];
            expPcQ.push_back(expTab[i]);
            if (expCnt != 3'd7) expCnt = expCnt + 3'd1;
            stepCycle();
            expPc = expPcQ.pop_front();
            checks++; if (imemIf.addr !== expPc) begin failures++; $display("[TB] FAIL b2b_pc[%0d]: got %h expected %h", i, imemIf.addr, expPc); end
            checks++; if (takenCnt !== expCnt) begin failures++; $display("[TB] FAIL b2b_cnt[%0d]: got %0d expected %0d", i, takenCnt, expCnt); end
        end
        clearInputs();
        checks++; if (trap !== 1'b0) begin failures++; $display("[TB] FAIL b2b_trap: got %b expected 0", trap); end
    endtask

    task automatic test_reset_hold();
        imemIf.ready = 1'b0;
        stepCycle();
        checks++; if (imemIf.addr !== 32'h60) begin failures++; $display("[TB] FAIL hold_pc: got %h expected %h", imemIf.addr, 32'h60); end
        #3 rst_n = 1'b0;
        #1;
        checks++; if (imemIf.addr !== 32'h0) begin failures++; $display("[TB] FAIL hold_reset_pc: got %h expected %h", imemIf.addr, 32'h0); end
        checks++; if (imemIf.valid !== 1'b0) begin failures++; $display("[TB] FAIL hold_reset_valid: got %b expected 0", imemIf.valid); end
        checks++; if (takenCnt !== '0) begin failures++; $display("[TB] FAIL hold_reset_cnt: got %0d expected 0", takenCnt); end
        expCnt = '0;
        #1 rst_n = 1'b1; imemIf.ready = 1'b1;
        stepCycle();
        checks++; if (imemIf.valid !== 1'b1) begin failures++; $display("[TB] FAIL reboot_valid: got %b expected 1", imemIf.valid); end
        checks++; if (imemIf.addr !== 32'h0) begin failures++; $display("[TB] FAIL reboot_pc: got %h expected %h", imemIf.addr, 32'h0); end
    endtask

    task automatic test_trap();
        isJalr = 1'b1; target = 32'h203;
        #1;
        checks++; if (taken !== 1'b1) begin failures++; $display("[TB] FAIL trap_taken: got %b expected 1", taken); end
        stepCycle();
        checks++; if (trap !== 1'b1) begin failures++; $display("[TB] FAIL trap_flag: got %b expected 1", trap); end
        checks++; if (imemIf.addr !== 32'h0) begin failures++; $display("[TB] FAIL trap_pc: got %h expected %h", imemIf.addr, 32'h0); end
        checks++; if (imemIf.valid !== 1'b0) begin failures++; $display("[TB] FAIL trap_valid: got %b expected 0", imemIf.valid); end
        clearInputs();
        isJal = 1'b1; target = 32'h80;
        stepCycle();
        checks++; if (imemIf.addr !== 32'h0) begin failures++; $display("[TB] FAIL trap_frozen_pc: got %h expected %h", imemIf.addr, 32'h0); end
        checks++; if (takenCnt !== expCnt) begin failures++; $display("[TB] FAIL trap_cnt: got %0d expected %0d", takenCnt, expCnt); end
        checks++; if (trap !== 1'b1) begin failures++; $display("[TB] FAIL trap_sticky: got %b expected 1", trap); end
        clearInputs();
        rst_n = 1'b0;
        #1;
        checks++; if (trap !== 1'b0) begin failures++; $display("[TB] FAIL trap_reset: got %b expected 0", trap); end
        rst_n = 1'b1;
    endtask

    initial begin
        imemIf.ready = 1'b0;
        test_reset();
        test_beq();
        test_unsigned();
        test_illegal();
        test_stall();
        test_back_to_back();
        test_reset_hold();
        test_trap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end
endmodule
